floor_request_latch: RTL and testbench

//   Input-side counterpart of the display path. Samples the raw floor push-buttons, synchronises
//   and debounces them, and latches each press as a pending floor request. Presents the pending
//   set as floor_btn[7:0] to the elevator controller and status display.
//   The controller clears a floor's request when it services that floor.

---
 rtl/elevator_pkg.sv | 29 ++
 rtl/floor_request_latch_if.sv | 26 ++
 rtl/floor_request_latch_debounce.sv | 45 ++++
 rtl/floor_request_latch.sv | 61 ++++++
 tb/tb_floor_request_latch.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types and defaults: floor count, index width, debounce length,
// plus thermometer-mask helpers for direction summaries.
package elevator_pkg;

  localparam int unsigned N_FLOORS        = 8;
  localparam int unsigned FLOOR_W         = $clog2(N_FLOORS);
  localparam int unsigned DEBOUNCE_CYCLES = 16;

  typedef logic [FLOOR_W-1:0]  floor_t;
  typedef logic [N_FLOORS-1:0] floor_mask_t;

  // Only in-range floor indices can ever be set in these masks.
  function automatic floor_mask_t below_mask(floor_t f);
    floor_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++)
      if (i < 32'(f)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic floor_mask_t above_mask(floor_t f);
    floor_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++)
      if (i > 32'(f)) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/floor_request_latch_if.sv
// Button/request bundle between the floor request latch (slave) and the
// controller side that drives buttons, car floor and service strobes (master).
interface floor_request_latch_if;
  import elevator_pkg::*;

  floor_mask_t btn_raw;
  floor_t      floor;
  logic        serviced;
  logic        clear_all;
  floor_mask_t floor_btn;
  floor_mask_t btn_press;
  logic        req_any;
  logic        req_above;
  logic        req_below;

  modport master (
    output btn_raw, floor, serviced, clear_all,
    input  floor_btn, btn_press, req_any, req_above, req_below
  );

  modport slave (
    input  btn_raw, floor, serviced, clear_all,
    output floor_btn, btn_press, req_any, req_above, req_below
  );

endinterface

// File: rtl/floor_request_latch_debounce.sv
// One button: 2-FF synchroniser, consecutive-cycle debounce counter, accepted
// level, and a rising-edge indication of the accepted level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      // Any sample agreeing with the accepted level restarts the count.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/floor_request_latch.sv
// Debounced floor push-button request latch with service/clear and request summaries.
// Optional REQ_DIR_SUMMARY_EN enables req_above/req_below; otherwise both read 0.
module floor_request_latch
  import elevator_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  floor_request_latch_if.slave bus
);

  floor_mask_t rise;
  floor_mask_t svc_mask;
  floor_mask_t latch_next;
  logic        above_next;
  logic        below_next;

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_raw[g]),
      .rise  (rise[g])
    );
  end

  // Service beats a same-cycle press on that floor: the doors are already open.
  always_comb begin
    svc_mask = '0;
    if (bus.serviced && (32'(bus.floor) < N_FLOORS))
      svc_mask[bus.floor] = 1'b1;
    if (bus.clear_all)
      latch_next = '0;
    else
      latch_next = (bus.floor_btn | rise) & ~svc_mask;
  end

`ifdef REQ_DIR_SUMMARY_EN
  assign above_next = |(latch_next & above_mask(bus.floor));
  assign below_next = |(latch_next & below_mask(bus.floor));
`else
  assign above_next = 1'b0;
  assign below_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.floor_btn <= '0;
      bus.btn_press <= '0;
      bus.req_any   <= 1'b0;
      bus.req_above <= 1'b0;
      bus.req_below <= 1'b0;
    end else begin
      bus.floor_btn <= latch_next;
      bus.btn_press <= rise;
      bus.req_any   <= |latch_next;
      bus.req_above <= above_next;
      bus.req_below <= below_next;
    end
  end

endmodule

// File: tb/tb_floor_request_latch.sv
// Bench for floor_request_latch: directed scenarios plus random button/service
// traffic, checked every cycle against a sample-window reference model.
module tb_floor_request_latch;
  import elevator_pkg::*;

  localparam int unsigned D = DEBOUNCE_CYCLES;
`ifdef REQ_DIR_SUMMARY_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  floor_request_latch_if bus ();

  floor_request_latch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples per button, newest in bit 0. A button's accepted
  // level flips once the D samples taken 2..D+1 edges ago all disagree with it.
  bit [D+1:0]          hist [N_FLOORS];
  bit [N_FLOORS-1:0]   m_stable, m_rose, m_press, m_req;
  bit                  m_any, m_above, m_below;

  task automatic model_reset();
    for (int i = 0; i < N_FLOORS; i++) hist[i] = '0;
    m_stable = '0; m_rose = '0; m_press = '0; m_req = '0;
    m_any = 1'b0; m_above = 1'b0; m_below = 1'b0;
  endtask

  task automatic model_step();
    bit all_diff;
    m_press = m_rose;
    for (int i = 0; i < N_FLOORS; i++) begin
      hist[i] = {hist[i][D:0], bus.btn_raw[i]};
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[i][k] == m_stable[i]) all_diff = 1'b0;
      m_rose[i] = 1'b0;
      if (all_diff) begin
        m_stable[i] = ~m_stable[i];
        m_rose[i]   = m_stable[i];
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (bus.clear_all)                         m_req[i] = 1'b0;
      else if (bus.serviced && bus.floor == i)   m_req[i] = 1'b0;
      else if (m_press[i])                       m_req[i] = 1'b1;
    end
    m_any = 1'b0; m_above = 1'b0; m_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (m_req[i]) m_any = 1'b1;
      if (m_req[i] && i > int'(bus.floor)) m_above = DIR_EN;
      if (m_req[i] && i < int'(bus.floor)) m_below = DIR_EN;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      #1;
      check_eq("floor_btn", bus.floor_btn, m_req);
      check_eq("btn_press", bus.btn_press, m_press);
      check_eq("req_any",   bus.req_any,   m_any);
      check_eq("req_above", bus.req_above, m_above);
      check_eq("req_below", bus.req_below, m_below);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_eq("rst_floor_btn", bus.floor_btn, 0);
    check_eq("rst_btn_press", bus.btn_press, 0);
    check_eq("rst_req_any",   bus.req_any,   0);
    check_eq("rst_req_above", bus.req_above, 0);
    check_eq("rst_req_below", bus.req_below, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit bouncy;
    bus.btn_raw   = '0;
    bus.floor     = '0;
    bus.serviced  = 1'b0;
    bus.clear_all = 1'b0;
    #1;
    do_reset();

    // Clean press on floor 5: accepted on the 19th edge.
    bus.btn_raw[5] = 1'b1;
    run(D + 2);
    check_eq("lat_before", bus.floor_btn, 0);
    run(1);
    check_eq("lat_floor_btn", bus.floor_btn, 8'h20);
    check_eq("lat_press", bus.btn_press, 8'h20);
    check_eq("lat_any", bus.req_any, 1);
    run(21);
    bus.btn_raw[5] = 1'b0;

    // Bouncing floor 2 then held.
    for (int k = 0; k < 12; k++) begin
      bus.btn_raw[2] = (k % 2 == 0);
      run(5);
    end
    check_eq("bounce_none", bus.floor_btn, 8'h20);
    bus.btn_raw[2] = 1'b1;
    run(D + 2);
    check_eq("bounce_before", bus.floor_btn, 8'h20);
    run(1);
    check_eq("bounce_press", bus.btn_press, 8'h04);
    check_eq("bounce_floor_btn", bus.floor_btn, 8'h24);

    // Service floor 2, then a service at an unrequested floor.
    bus.floor = 3'd2; bus.serviced = 1'b1;
    run(1);
    bus.serviced = 1'b0;
    check_eq("svc_clear", bus.floor_btn, 8'h20);
    bus.floor = 3'd7; bus.serviced = 1'b1;
    run(1);
    bus.serviced = 1'b0;
    check_eq("svc_nochange", bus.floor_btn, 8'h20);

    // Floor 3 press collides with service at floor 3; floor 6 press still lands.
    bus.btn_raw[2] = 1'b0;
    bus.btn_raw[3] = 1'b1; bus.btn_raw[6] = 1'b1;
    run(D + 2);
    bus.floor = 3'd3; bus.serviced = 1'b1;
    run(1);
    bus.serviced = 1'b0;
    check_eq("coll_floor_btn", bus.floor_btn, 8'h60);
    check_eq("coll_press", bus.btn_press, 8'h48);
    bus.btn_raw[3] = 1'b0; bus.btn_raw[6] = 1'b0;

    // Held button serviced stays clear until released and pressed again.
    bus.btn_raw[1] = 1'b1;
    run(D + 3);
    check_eq("held_set", bus.floor_btn[1], 1);
    bus.floor = 3'd1; bus.serviced = 1'b1;
    run(1);
    bus.serviced = 1'b0;
    run(30);
    check_eq("held_clear", bus.floor_btn[1], 0);
    bus.btn_raw[1] = 1'b0;
    run(D + 4);
    bus.btn_raw[1] = 1'b1;
    run(D + 3);
    check_eq("repress_set", bus.floor_btn[1], 1);

    // Reset mid-debounce with requests {0,7}, then direction summary.
    bus.clear_all = 1'b1;
    run(1);
    bus.clear_all = 1'b0;
    check_eq("clear_all", bus.floor_btn, 0);
    bus.btn_raw = 8'h81;
    run(D + 3);
    check_eq("req_0_7", bus.floor_btn, 8'h81);
    bus.btn_raw[4] = 1'b1;
    run(8);
    do_reset();
    bus.btn_raw = 8'h81;
    bus.floor   = 3'd4;
    run(D + 2);
    check_eq("post_rst_before", bus.floor_btn, 0);
    run(1);
    check_eq("post_rst_req", bus.floor_btn, 8'h81);
    check_eq("dir_above", bus.req_above, DIR_EN);
    check_eq("dir_below", bus.req_below, DIR_EN);

    // Random traffic with quiet and bouncy periods and one mid-run reset.
    bouncy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bouncy = ~bouncy;
      for (int i = 0; i < N_FLOORS; i++)
        if ($urandom_range(0, 99) < (bouncy ? 20 : 3)) bus.btn_raw[i] = ~bus.btn_raw[i];
      bus.floor     = floor_t'($urandom_range(0, N_FLOORS - 1));
      bus.serviced  = ($urandom_range(0, 5) == 0);
      bus.clear_all = ($urandom_range(0, 299) == 0);
      if (c == 1500) do_reset();
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
